// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives PC enable, PC source select, IF/ID enable and
// flush, and the registered redirect target, across boot, stalls, taken
// branches and halt/resume.
// Optional build macro: FETCH_PERF_CNT_EN enables the saturating performance
// counters. Without it the counter ports are tied to zero and no counter flops
// are built.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// BOOT     | post-reset idle, wait counter counting down, no fetch
// RUN      | normal fetch; halt > branch > stall priority
// REDIRECT | one cycle: PC loads branch_address, IF/ID gets a bubble
// HALT     | fetch stopped; branches are parked as a pending redirect
module fetch_sequencer #(
  parameter int RESET_WAIT_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stall_req_i,
  input  logic             branch_req_i,
  input  logic [31:0]      branch_target_i,
  input  logic             halt_req_i,
  input  logic             resume_req_i,
  output logic             pc_en_o,
  output logic             pc_src_o,
  output logic [31:0]      branch_address_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             fetch_valid_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] redirect_count_o
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(RESET_WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] target_q, target_d;
  logic        pend_q, pend_d;

  // State, boot wait counter, redirect target and pending flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= BOOT;
      wait_q   <= WAIT_INIT;
      target_q <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      target_q <= target_d;
      pend_q   <= pend_d;
    end
  end

  // Next-state and combinational enables from current state and requests.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    target_d      = target_q;
    pend_d        = pend_q;
    pc_en_o       = 1'b0;
    pc_src_o      = 1'b0;
    ifid_en_o     = 1'b0;
    ifid_flush_o  = 1'b0;
    fetch_valid_o = 1'b0;
    case (state_q)
      BOOT: begin
        // BOOT always lasts at least one cycle, so a wait of 0 or 1 both
        // leave on the first edge after reset release.
        if (wait_q <= 4'd1) begin
          wait_d  = 4'd0;
          state_d = RUN;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RUN: begin
        if (halt_req_i) begin
          state_d = HALT;
          if (branch_req_i) begin
            target_d = branch_target_i;
            pend_d   = 1'b1;
          end
        end else if (branch_req_i) begin
          target_d     = branch_target_i;
          ifid_en_o    = 1'b1;
          ifid_flush_o = 1'b1;
          state_d      = REDIRECT;
        end else if (stall_req_i) begin
          fetch_valid_o = 1'b1;
        end else begin
          pc_en_o       = 1'b1;
          ifid_en_o     = 1'b1;
          fetch_valid_o = 1'b1;
        end
      end
      REDIRECT: begin
        pc_src_o     = 1'b1;
        pc_en_o      = 1'b1;
        ifid_en_o    = 1'b1;
        ifid_flush_o = 1'b1;
        pend_d       = 1'b0;
        state_d      = halt_req_i ? HALT : RUN;
      end
      HALT: begin
        if (branch_req_i) begin
          target_d = branch_target_i;
          pend_d   = 1'b1;
        end
        // A branch arriving together with resume still gets redirected to.
        if (!halt_req_i && resume_req_i) begin
          state_d = (pend_q || branch_req_i) ? REDIRECT : RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign branch_address_o = target_q;
  assign state_o          = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q, redir_cnt_q;
  logic             fetch_inc, stall_inc, redir_inc;

  assign fetch_inc = fetch_valid_o & ifid_en_o;
  assign stall_inc = (state_q == RUN) & stall_req_i & ~halt_req_i & ~branch_req_i;
  assign redir_inc = (state_d == REDIRECT) & (state_q != REDIRECT);

  // Saturating performance counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (fetch_inc && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redir_inc && (redir_cnt_q != '1)) redir_cnt_q <= redir_cnt_q + 1'b1;
    end
  end

  assign fetch_count_o    = fetch_cnt_q;
  assign stall_count_o    = stall_cnt_q;
  assign redirect_count_o = redir_cnt_q;
`else
  assign fetch_count_o    = '0;
  assign stall_count_o    = '0;
  assign redirect_count_o = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: boot timing, a per-cycle vector table
// through RUN/REDIRECT/HALT, and reset asserted in the middle of a redirect.
module tb_fetch_sequencer;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        stall_req, branch_req, halt_req, resume_req;
  logic [31:0] branch_target;
  logic        pc_en, pc_src, ifid_en, ifid_flush, fetch_valid;
  logic [31:0] branch_address;
  logic [1:0]  state;
  logic [31:0] fetch_count, stall_count, redirect_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.RESET_WAIT_CYCLES(2), .CNT_W(32)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .stall_req_i      (stall_req),
    .branch_req_i     (branch_req),
    .branch_target_i  (branch_target),
    .halt_req_i       (halt_req),
    .resume_req_i     (resume_req),
    .pc_en_o          (pc_en),
    .pc_src_o         (pc_src),
    .branch_address_o (branch_address),
    .ifid_en_o        (ifid_en),
    .ifid_flush_o     (ifid_flush),
    .fetch_valid_o    (fetch_valid),
    .state_o          (state),
    .fetch_count_o    (fetch_count),
    .stall_count_o    (stall_count),
    .redirect_count_o (redirect_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl packs {pc_en, pc_src, ifid_en, ifid_flush, fetch_valid}
  localparam logic [4:0] C_RUN  = 5'b10101;
  localparam logic [4:0] C_BR   = 5'b00110;
  localparam logic [4:0] C_STL  = 5'b00001;
  localparam logic [4:0] C_ZERO = 5'b00000;
  localparam logic [4:0] C_RED  = 5'b11110;

  typedef struct {
    logic        s, b, h, r;
    logic [31:0] tgt;
    logic [1:0]  st;
    logic [4:0]  ctl;
    logic [31:0] ba;
    int          fc, sc, rc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, b, h, r, input logic [31:0] tgt,
                     input logic [1:0] st, input logic [4:0] ctl,
                     input logic [31:0] ba, input int fc, sc, rc);
    vec_t v;
    v.s = s; v.b = b; v.h = h; v.r = r; v.tgt = tgt;
    v.st = st; v.ctl = ctl; v.ba = ba; v.fc = fc; v.sc = sc; v.rc = rc;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ctl_now();
    return {pc_en, pc_src, ifid_en, ifid_flush, fetch_valid};
  endfunction

  task automatic chk_cnt(input string name, input int fc, sc, rc);
    logic [95:0] e;
    e = PERF ? {32'(fc), 32'(sc), 32'(rc)} : 96'd0;
    chk(name, {fetch_count, stall_count, redirect_count}, e);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_req = 0; branch_req = 0; halt_req = 0; resume_req = 0;
    branch_target = 32'd0;

    //     s b h r  target        st ctl     baddr        fc sc rc
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h0,   1, 0, 0);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h0,   2, 0, 0);
    add(0,1,0,0, 32'h40,      1, C_BR,   32'h0,   3, 0, 0);
    add(0,0,0,0, 32'h0,       2, C_RED,  32'h40,  3, 0, 1);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h40,  3, 0, 1);
    add(1,0,0,0, 32'h0,       1, C_STL,  32'h40,  4, 0, 1);
    add(1,0,0,0, 32'h0,       1, C_STL,  32'h40,  4, 1, 1);
    add(1,0,0,0, 32'h0,       1, C_STL,  32'h40,  4, 2, 1);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h40,  4, 3, 1);
    add(1,1,0,0, 32'h80,      1, C_BR,   32'h40,  5, 3, 1);
    add(1,1,0,0, 32'h999,     2, C_RED,  32'h80,  5, 3, 2);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h80,  5, 3, 2);
    add(0,1,1,0, 32'h100,     1, C_ZERO, 32'h80,  6, 3, 2);
    add(0,0,0,0, 32'h0,       3, C_ZERO, 32'h100, 6, 3, 2);
    add(0,0,0,0, 32'h0,       3, C_ZERO, 32'h100, 6, 3, 2);
    add(0,0,0,0, 32'h0,       3, C_ZERO, 32'h100, 6, 3, 2);
    add(0,0,0,0, 32'h0,       3, C_ZERO, 32'h100, 6, 3, 2);
    add(0,0,0,1, 32'h0,       3, C_ZERO, 32'h100, 6, 3, 2);
    add(0,0,0,0, 32'h0,       2, C_RED,  32'h100, 6, 3, 3);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h100, 6, 3, 3);
    add(0,1,0,0, 32'h200,     1, C_BR,   32'h100, 7, 3, 3);
    add(0,0,1,0, 32'h0,       2, C_RED,  32'h200, 7, 3, 4);
    add(0,0,0,0, 32'h0,       3, C_ZERO, 32'h200, 7, 3, 4);
    add(0,1,0,0, 32'h300,     3, C_ZERO, 32'h200, 7, 3, 4);
    add(0,1,0,0, 32'h304,     3, C_ZERO, 32'h300, 7, 3, 4);
    add(0,0,1,1, 32'h0,       3, C_ZERO, 32'h304, 7, 3, 4);
    add(0,0,0,1, 32'h0,       3, C_ZERO, 32'h304, 7, 3, 4);
    add(0,0,0,0, 32'h0,       2, C_RED,  32'h304, 7, 3, 5);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h304, 7, 3, 5);
    add(1,0,1,0, 32'h0,       1, C_ZERO, 32'h304, 8, 3, 5);
    add(0,0,0,1, 32'h0,       3, C_ZERO, 32'h304, 8, 3, 5);
    add(0,0,0,0, 32'h0,       1, C_RUN,  32'h304, 8, 3, 5);

    // Reset state
    #12;
    chk("reset_state", state, 2'd0);
    chk("reset_ctl", ctl_now(), C_ZERO);
    chk("reset_baddr", branch_address, 32'h0);
    chk_cnt("reset_cnt", 0, 0, 0);

    // Boot: two BOOT cycles, RUN on the third
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("boot_c1_state", state, 2'd0);
    chk("boot_c1_ctl", ctl_now(), C_ZERO);
    @(posedge clk); #4;
    chk("boot_c2_state", state, 2'd0);
    chk("boot_c2_ctl", ctl_now(), C_ZERO);
    @(posedge clk); #4;
    chk("boot_c3_state", state, 2'd1);
    chk("boot_c3_ctl", ctl_now(), C_RUN);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      stall_req     = tbl[i].s;
      branch_req    = tbl[i].b;
      halt_req      = tbl[i].h;
      resume_req    = tbl[i].r;
      branch_target = tbl[i].tgt;
      #3;
      chk($sformatf("row%0d_state", i), state, tbl[i].st);
      chk($sformatf("row%0d_ctl", i), ctl_now(), tbl[i].ctl);
      chk($sformatf("row%0d_baddr", i), branch_address, tbl[i].ba);
      chk_cnt($sformatf("row%0d_cnt", i), tbl[i].fc, tbl[i].sc, tbl[i].rc);
    end

    // Reset asserted mid-REDIRECT: immediate BOOT, pending target lost
    @(posedge clk); #1;
    stall_req = 0; halt_req = 0; resume_req = 0;
    branch_req = 1; branch_target = 32'h500;
    @(posedge clk); #1;
    branch_req = 0; branch_target = 32'h0;
    #1;
    chk("pre_rst_state", state, 2'd2);
    chk("pre_rst_baddr", branch_address, 32'h500);
    rst_n = 1'b0;
    #1;
    chk("midrst_state", state, 2'd0);
    chk("midrst_ctl", ctl_now(), C_ZERO);
    chk("midrst_baddr", branch_address, 32'h0);
    chk_cnt("midrst_cnt", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rb_c1_state", state, 2'd0);
    @(posedge clk); #4;
    chk("rb_c2_state", state, 2'd0);
    @(posedge clk); #4;
    chk("rb_c3_state", state, 2'd1);
    chk("rb_c3_ctl", ctl_now(), C_RUN);
    chk("rb_c3_baddr", branch_address, 32'h0);
    @(posedge clk); #4;
    chk("rb_c4_state", state, 2'd1);
    chk("rb_c4_ctl", ctl_now(), C_RUN);
    chk_cnt("rb_c4_cnt", 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control FSM for the single-issue fetch stage. It sequences the program counter, IF/ID pipeline register and PC source mux after reset, on hazard stalls, taken branches and halt/resume. It sits between the hazard/branch logic in EX and the fetch datapath. It drives the PC enable, the PC mux select and the branch address, and flushes wrong-path instructions.

## Interface
- RESET_WAIT_CYCLES, 2, idle cycles after reset release before the first fetch (0..15)
- CNT_W, 32, width of the performance counters
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall_req  in  1  hazard unit: hold PC and IF/ID this cycle (level)
- branch_req  in  1  taken branch resolved in EX (one-cycle pulse)
- branch_target  in  32  target address, valid with branch_req
- halt_req  in  1  stop fetching (pulse or level)
- resume_req  in  1  leave HALT (pulse)
- pc_en  out  1  PC register load enable
- pc_src  out  1  PC mux select: 0 = PC+4, 1 = branch_address
- branch_address  out  32  registered redirect target
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID load a bubble (valid = 0)
- fetch_valid  out  1  instruction in IF is on the correct path
- state  out  2  FSM state: 0 BOOT, 1 RUN, 2 REDIRECT, 3 HALT
- fetch_count, stall_count, redirect_count  out  CNT_W each  performance counters

## Operation
- Reset (reset = 0): state = BOOT, wait counter = RESET_WAIT_CYCLES, target register = 0, pend = 0, counters = 0.
- Reset values of outputs: all 1-bit outputs 0, branch_address = 0.
- **BOOT**
  - All enables are 0.
  - The wait counter decrements each cycle; the FSM goes to RUN when it reaches 0.
  - With RESET_WAIT_CYCLES = 0 the FSM goes to RUN on the first edge after reset release.
  - halt_req and branch_req are ignored.
- **RUN**, priority halt_req > branch_req > stall_req:
  - halt_req: pc_en = ifid_en = 0. Next state is HALT. If branch_req is also set, the target is latched and pend = 1.
  - branch_req: target is latched. pc_en = 0, ifid_en = 1, ifid_flush = 1, fetch_valid = 0. Next state is REDIRECT.
  - stall_req: pc_en = ifid_en = 0, fetch_valid = 1. State stays RUN.
  - None of the above: pc_en = ifid_en = fetch_valid = 1, pc_src = 0.
- **REDIRECT** (exactly one cycle):
  - pc_src = 1, pc_en = 1, ifid_en = 1, ifid_flush = 1, fetch_valid = 0. pend is cleared.
  - branch_req and stall_req are ignored: the requester is on the wrong path, and the redirect cannot be stalled.
  - halt_req is deferred: the redirect completes and the FSM enters HALT instead of RUN.
- **HALT**
  - pc_en = ifid_en = ifid_flush = fetch_valid = 0.
  - A branch_req while halted latches the target and sets pend = 1. The latest one wins.
  - On resume_req the FSM goes to REDIRECT if pend = 1, otherwise to RUN.
  - If resume_req and halt_req are both set, halt_req wins and the FSM stays in HALT.
- branch_address always reflects the target register. The target register holds its value until the next capture.

## Timing
- pc_en, ifid_en, ifid_flush, fetch_valid and pc_src are combinational from the state and the current-cycle requests. They must settle before the clk edge that the datapath samples.
- Taken branch penalty:
  - branch_req in cycle N.
  - Cycle N+1 is REDIRECT. The PC loads the target at the end of N+1.
  - In cycle N+2 the FSM is in RUN, fetching the target with fetch_valid = 1.
  - Two bubbles enter IF/ID.
- Stall has zero latency: PC and IF/ID hold in the same cycle that stall_req is high.
- Asynchronous reset asserted mid-REDIRECT or mid-HALT returns the FSM to BOOT immediately. The pending target is lost.

## Configuration
- FETCH_PERF_CNT_EN is defined:
  - fetch_count increments on cycles with fetch_valid & ifid_en.
  - stall_count increments on RUN cycles with stall_req blocking.
  - redirect_count increments on entry to REDIRECT.
  - All three counters saturate at 2^CNT_W-1.
- FETCH_PERF_CNT_EN is undefined: the ports remain and are tied to 0. No counter flops are present.

## Test plan
- Reset release with RESET_WAIT_CYCLES = 2 -> state = 0 for 2 cycles with pc_en = 0, then state = 1 and pc_en = fetch_valid = 1 on the 3rd cycle.
- In RUN, branch_req with branch_target = 0x0000_0040 -> same cycle ifid_flush = 1, pc_en = 0. Next cycle pc_src = 1, branch_address = 0x40, pc_en = 1. The cycle after that is RUN with fetch_valid = 1. redirect_count = 1.
- stall_req high for 3 cycles in RUN -> pc_en = ifid_en = 0 during exactly those cycles. stall_count = 3. fetch_count is frozen.
- branch_req and stall_req in the same RUN cycle -> branch wins: REDIRECT follows, and stall_count is unchanged.
- halt_req and branch_req (target 0x100) in the same cycle, then resume_req 5 cycles later -> HALT with outputs 0, then REDIRECT with branch_address = 0x100, then RUN.
- reset asserted during REDIRECT -> all outputs 0 and state = 0 immediately. After release, no redirect is performed.
